wb_exc_ctrl: RTL and testbench

- Writeback-stage commit controller; it is the initiator that drives the csr register file interface.
- Turns retiring instructions into CSR read/write/exchange accesses, exception commits and ertn commits.
- Issues a registered pipeline flush with a redirect PC, then blocks further commits for a drain window until fetch has restarted.
- Sits between the WB pipeline register, the regfile write port and the csr block.

---
 rtl/wb_exc_ctrl.sv | 171 +++++++++++++++++
 tb/tb_wb_exc_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_exc_ctrl.sv
// Writeback commit controller: turns retiring instructions into CSR accesses,
// exception/ertn commits and a registered flush followed by a drain window.
module wb_exc_ctrl #(
    parameter int          DRAIN_CYCLES     = 3,
    parameter logic [5:0]  EENTRY_ECODE_INT = 6'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [1:0]  wb_csr_op,
    input  logic [13:0] wb_csr_num,
    input  logic [31:0] wb_rj_val,
    input  logic [31:0] wb_rd_val,
    input  logic        wb_ertn,
    input  logic [4:0]  wb_exc,
    input  logic [4:0]  wb_dest,
    output logic [13:0] csr_num,
    input  logic [31:0] csr_rdata,
    output logic        csr_we,
    output logic [31:0] csr_wdata,
    output logic [31:0] csr_wmask,
    output logic        EXC_signal,
    output logic        ERTN_signal,
    output logic [5:0]  EXC_ecode,
    output logic [8:0]  EXC_esubcode,
    output logic [31:0] EXC_pc,
    input  logic [31:0] CSR_2_IF_pc,
    input  logic        INT_signal,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        commit_block
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      state_r;
    logic [3:0]  drain_cnt_r;
    logic        int_pending_r;

    logic        commit_s;
    logic        exc_s;
    logic        ertn_s;
    logic        csr_s;
    logic        csr_wr_s;
    logic        int_take_s;

    // Priority encode the exception cause; a pending interrupt beats every flag.
    function automatic logic [5:0] exc_ecode_f(input logic intp, input logic [4:0] exc);
        logic [5:0] code;
        if (intp)        code = EENTRY_ECODE_INT;
        else if (exc[4]) code = 6'h08;
        else if (exc[3]) code = 6'h0D;
        else if (exc[2]) code = 6'h0B;
        else if (exc[1]) code = 6'h0C;
        else if (exc[0]) code = 6'h09;
        else             code = 6'h00;
        return code;
    endfunction

    // Classify the current commit: exception beats ertn, ertn beats CSR access.
    always_comb begin
        commit_s   = (state_r == ST_IDLE) && wb_valid;
        exc_s      = commit_s && (int_pending_r || (wb_exc != 5'd0));
        ertn_s     = commit_s && !exc_s && wb_ertn;
        csr_s      = commit_s && !exc_s && !wb_ertn && (wb_csr_op != 2'd0);
        csr_wr_s   = csr_s && ((wb_csr_op == 2'd2) || (wb_csr_op == 2'd3));
        int_take_s = exc_s && int_pending_r;
    end

    // Combinational CSR, regfile and exception outputs for the committing instruction.
    always_comb begin
        csr_num      = 14'd0;
        csr_we       = 1'b0;
        csr_wdata    = 32'd0;
        csr_wmask    = 32'd0;
        EXC_signal   = 1'b0;
        ERTN_signal  = 1'b0;
        EXC_ecode    = 6'd0;
        EXC_esubcode = 9'd0;
        EXC_pc       = 32'd0;
        rf_we        = 1'b0;
        rf_waddr     = 5'd0;
        rf_wdata     = 32'd0;
        if (exc_s) begin
            EXC_signal = 1'b1;
            EXC_ecode  = exc_ecode_f(int_pending_r, wb_exc);
            EXC_pc     = wb_pc;
        end else if (ertn_s) begin
            ERTN_signal = 1'b1;
        end else if (csr_s) begin
            csr_num  = wb_csr_num;
            rf_we    = (wb_dest != 5'd0);
            rf_waddr = wb_dest;
            rf_wdata = csr_rdata;
            if (csr_wr_s) begin
                csr_we    = 1'b1;
                csr_wdata = wb_rd_val;
                csr_wmask = (wb_csr_op == 2'd3) ? wb_rj_val : 32'hFFFF_FFFF;
            end else begin
                csr_we = 1'b0;
            end
        end else begin
            csr_we = 1'b0;
        end
    end

    // Commit state machine with registered flush pulse and redirect PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            drain_cnt_r <= 4'd0;
            flush       <= 1'b0;
            flush_pc    <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (exc_s || ertn_s) begin
                        state_r  <= ST_FLUSH;
                        flush    <= 1'b1;
                        flush_pc <= CSR_2_IF_pc;
                    end else if (csr_wr_s) begin
                        state_r  <= ST_FLUSH;
                        flush    <= 1'b1;
                        flush_pc <= wb_pc + 32'd4;
                    end else begin
                        flush <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    flush       <= 1'b0;
                    state_r     <= ST_DRAIN;
                    drain_cnt_r <= DRAIN_LOAD;
                end
                ST_DRAIN: begin
                    flush <= 1'b0;
                    if (drain_cnt_r == 4'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    flush   <= 1'b0;
                end
            endcase
        end
    end

    // Interrupt request latch: a new request wins over the clear from a taken interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            int_pending_r <= 1'b0;
        end else begin
            int_pending_r <= INT_signal | (int_pending_r & ~int_take_s);
        end
    end

    assign commit_block = (state_r != ST_IDLE);

endmodule

// File: tb/tb_wb_exc_ctrl.sv
// Self-checking bench for wb_exc_ctrl: directed test-plan steps followed by
// random traffic, all checked against a cycle-count reference model.
module tb_wb_exc_ctrl;

    localparam int D = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [1:0]  wb_csr_op;
    logic [13:0] wb_csr_num;
    logic [31:0] wb_rj_val;
    logic [31:0] wb_rd_val;
    logic        wb_ertn;
    logic [4:0]  wb_exc;
    logic [4:0]  wb_dest;
    logic [13:0] csr_num;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_wmask;
    logic        EXC_signal;
    logic        ERTN_signal;
    logic [5:0]  EXC_ecode;
    logic [8:0]  EXC_esubcode;
    logic [31:0] EXC_pc;
    logic [31:0] CSR_2_IF_pc;
    logic        INT_signal;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        commit_block;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: remaining blocked cycles (flush cycle + drain), pending interrupt, redirect PC.
    int          m_cnt;
    logic        m_int;
    logic [31:0] m_fpc;
    logic        m_trig;
    logic [31:0] m_trig_pc;
    logic        m_int_take;
    logic [5:0]  codes [5] = '{6'h09, 6'h0C, 6'h0B, 6'h0D, 6'h08};

    always #5 clk = ~clk;

    wb_exc_ctrl #(.DRAIN_CYCLES(D), .EENTRY_ECODE_INT(6'h00)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_csr_op(wb_csr_op), .wb_csr_num(wb_csr_num), .wb_rj_val(wb_rj_val),
        .wb_rd_val(wb_rd_val), .wb_ertn(wb_ertn), .wb_exc(wb_exc), .wb_dest(wb_dest),
        .csr_num(csr_num), .csr_rdata(csr_rdata), .csr_we(csr_we),
        .csr_wdata(csr_wdata), .csr_wmask(csr_wmask), .EXC_signal(EXC_signal),
        .ERTN_signal(ERTN_signal), .EXC_ecode(EXC_ecode), .EXC_esubcode(EXC_esubcode),
        .EXC_pc(EXC_pc), .CSR_2_IF_pc(CSR_2_IF_pc), .INT_signal(INT_signal),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flush(flush),
        .flush_pc(flush_pc), .commit_block(commit_block)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        reset = 1'b0; wb_valid = 1'b0; wb_pc = 32'd0; wb_csr_op = 2'd0;
        wb_csr_num = 14'd0; wb_rj_val = 32'd0; wb_rd_val = 32'd0; wb_ertn = 1'b0;
        wb_exc = 5'd0; wb_dest = 5'd0; csr_rdata = 32'd0; INT_signal = 1'b0;
    endtask

    // Sample at the falling edge and compare every output against the model.
    task automatic pre();
        logic en, ex, er, cs, wr;
        logic [5:0] ec;
        @(negedge clk);
        en = (m_cnt == 0) && wb_valid;
        ex = en && (m_int || (wb_exc != 5'd0));
        er = en && !ex && wb_ertn;
        cs = en && !ex && !wb_ertn && (wb_csr_op != 2'd0);
        wr = cs && (wb_csr_op != 2'd1);
        ec = 6'd0;
        for (int i = 0; i < 5; i++) if (wb_exc[i]) ec = codes[i];
        if (m_int) ec = 6'h00;
        chk("exc_signal", 32'(EXC_signal), 32'(ex));
        chk("exc_ecode", 32'(EXC_ecode), ex ? 32'(ec) : 32'd0);
        chk("exc_esubcode", 32'(EXC_esubcode), 32'd0);
        chk("exc_pc", EXC_pc, ex ? wb_pc : 32'd0);
        chk("ertn_signal", 32'(ERTN_signal), 32'(er));
        chk("csr_num", 32'(csr_num), cs ? 32'(wb_csr_num) : 32'd0);
        chk("csr_we", 32'(csr_we), 32'(wr));
        chk("csr_wdata", csr_wdata, wr ? wb_rd_val : 32'd0);
        chk("csr_wmask", csr_wmask, wr ? ((wb_csr_op == 2'd3) ? wb_rj_val : 32'hFFFF_FFFF) : 32'd0);
        chk("rf_we", 32'(rf_we), 32'(cs && (wb_dest != 5'd0)));
        chk("rf_waddr", 32'(rf_waddr), cs ? 32'(wb_dest) : 32'd0);
        chk("rf_wdata", rf_wdata, cs ? csr_rdata : 32'd0);
        chk("flush", 32'(flush), 32'(m_cnt == D + 1));
        chk("flush_pc", flush_pc, m_fpc);
        chk("commit_block", 32'(commit_block), 32'(m_cnt != 0));
        m_trig     = ex || er || wr;
        m_trig_pc  = (ex || er) ? CSR_2_IF_pc : wb_pc + 32'd4;
        m_int_take = ex && m_int;
    endtask

    // Advance the model across the rising edge.
    task automatic post();
        @(posedge clk);
        if (reset) begin
            m_cnt = 0; m_int = 1'b0; m_fpc = 32'd0;
        end else begin
            if (m_trig) begin
                m_cnt = D + 1; m_fpc = m_trig_pc;
            end else if (m_cnt > 0) begin
                m_cnt--;
            end
            m_int = INT_signal | (m_int & ~m_int_take);
        end
        #1;
    endtask

    task automatic idle_n(input int n);
        clr_in();
        for (int i = 0; i < n; i++) begin pre(); post(); end
    endtask

    initial begin
        clr_in();
        CSR_2_IF_pc = 32'd0;
        reset = 1'b1;
        @(posedge clk); #1;
        m_cnt = 0; m_int = 1'b0; m_fpc = 32'd0;
        pre(); chk("reset_flush", 32'(flush), 32'd0); chk("reset_block", 32'(commit_block), 32'd0); post();
        idle_n(1);

        // csrrd
        wb_valid = 1'b1; wb_csr_op = 2'd1; wb_csr_num = 14'h00C; csr_rdata = 32'h1234; wb_dest = 5'd5;
        pre();
        chk("tp1_rf_we", 32'(rf_we), 32'd1); chk("tp1_rf_waddr", 32'(rf_waddr), 32'd5);
        chk("tp1_rf_wdata", rf_wdata, 32'h1234); chk("tp1_csr_we", 32'(csr_we), 32'd0);
        post();
        clr_in(); pre(); chk("tp1_no_flush", 32'(flush), 32'd0); post();

        // csrxchg with refetch flush
        wb_valid = 1'b1; wb_csr_op = 2'd3; wb_rj_val = 32'h0000FF00; wb_rd_val = 32'hABCDABCD;
        wb_pc = 32'h1C000100;
        pre(); chk("tp2_wmask", csr_wmask, 32'h0000FF00); chk("tp2_we", 32'(csr_we), 32'd1); post();
        clr_in();
        pre(); chk("tp2_flush", 32'(flush), 32'd1); chk("tp2_flush_pc", flush_pc, 32'h1C000104); post();
        for (int i = 0; i < D; i++) begin pre(); chk("tp2_block", 32'(commit_block), 32'd1); post(); end
        pre(); chk("tp2_unblock", 32'(commit_block), 32'd0); post();

        // syscall
        wb_valid = 1'b1; wb_exc = 5'b00100; wb_pc = 32'h1C000200; CSR_2_IF_pc = 32'h1C008000;
        pre(); chk("tp3_exc", 32'(EXC_signal), 32'd1); chk("tp3_ecode", 32'(EXC_ecode), 32'h0B);
        chk("tp3_pc", EXC_pc, 32'h1C000200); chk("tp3_we", 32'(csr_we), 32'd0); post();
        clr_in();
        pre(); chk("tp3_flush_pc", flush_pc, 32'h1C008000); post();
        idle_n(D);

        // adef+ale, then interrupt latched during drain
        wb_valid = 1'b1; wb_exc = 5'b10001; wb_pc = 32'h1C000220;
        pre(); chk("tp4_ecode", 32'(EXC_ecode), 32'h08); post();
        idle_n(2);
        INT_signal = 1'b1; pre(); post();
        idle_n(D - 1);
        wb_valid = 1'b1; wb_pc = 32'h1C000240;
        pre(); chk("tp4_int_exc", 32'(EXC_signal), 32'd1); chk("tp4_int_ecode", 32'(EXC_ecode), 32'h00); post();
        idle_n(D + 1);
        wb_valid = 1'b1; wb_pc = 32'h1C000244;
        pre(); chk("tp4_int_cleared", 32'(EXC_signal), 32'd0); post();

        // ertn, commits ignored during the blocked window
        clr_in(); wb_valid = 1'b1; wb_ertn = 1'b1; CSR_2_IF_pc = 32'h1C000300;
        pre(); chk("tp5_ertn", 32'(ERTN_signal), 32'd1); post();
        clr_in(); wb_valid = 1'b1; wb_csr_op = 2'd2; wb_pc = 32'h1C000400;
        pre(); chk("tp5_ertn_off", 32'(ERTN_signal), 32'd0); chk("tp5_flush_pc", flush_pc, 32'h1C000300); post();
        for (int i = 0; i < D; i++) begin pre(); chk("tp5_ignored", 32'(csr_we), 32'd0); post(); end
        pre(); chk("tp5_resume", 32'(csr_we), 32'd1); post();

        // reset during the flush cycle
        clr_in(); reset = 1'b1;
        pre(); chk("tp6_flush_before", 32'(flush), 32'd1); post();
        clr_in(); wb_valid = 1'b1; wb_csr_op = 2'd1; wb_dest = 5'd7; csr_rdata = 32'h55AA;
        pre(); chk("tp6_flush", 32'(flush), 32'd0); chk("tp6_block", 32'(commit_block), 32'd0);
        chk("tp6_rf_we", 32'(rf_we), 32'd1); post();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 49) == 0);
            wb_valid    = ($urandom_range(0, 9) < 6);
            wb_pc       = $urandom();
            wb_csr_op   = 2'($urandom_range(0, 3));
            wb_csr_num  = 14'($urandom());
            wb_rj_val   = $urandom();
            wb_rd_val   = $urandom();
            wb_ertn     = ($urandom_range(0, 7) == 0);
            wb_exc      = ($urandom_range(0, 3) == 0) ? 5'($urandom()) : 5'd0;
            wb_dest     = 5'($urandom());
            csr_rdata   = $urandom();
            CSR_2_IF_pc = $urandom();
            INT_signal  = ($urandom_range(0, 15) == 0);
            pre(); post();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
